vec_add_accum: RTL and testbench

Parametrised N-lane fp32 vector adder/accumulator for the force-reduction path. It replaces the fixed 3-lane, single-mode adder with two modes: a pipelined element-wise add/subtract of two vector streams, and a streaming accumulator that sums many vectors and emits the total on flush. Every vector word carries a null flag in its MSB, and null words propagate as bubbles. All lanes use the existing combinational `fp32_add` (ports a, b, o, sub).

---
 rtl/vec_add_accum_if.sv | 19 +
 rtl/vec_add_accum.sv | 161 ++++++++++++++++
 tb/tb_vec_add_accum.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/vec_add_accum_if.sv
// Vector adder/accumulator operand, control and result bundle.
// The master drives operands, mode and flush; the slave returns the result word and status.
interface vec_add_accum_if #(
  parameter int LANES = 3,
  parameter int W     = 32,
  parameter int CNT_W = 16
);
  logic [LANES*W:0]  a;
  logic [LANES*W:0]  b;
  logic [1:0]        mode;
  logic              flush;
  logic [LANES*W:0]  o;
  logic              en;
  logic [CNT_W-1:0]  o_count;
  logic              acc_busy;

  modport master (output a, b, mode, flush, input o, en, o_count, acc_busy);
  modport slave  (input a, b, mode, flush, output o, en, o_count, acc_busy);
endinterface

// File: rtl/vec_add_accum.sv
// N-lane fp32 element-wise add/sub or streaming accumulator with flush; PIPE-cycle latency.
// No backpressure: one input per cycle in every mode, null words travel as bubbles.
module fp32_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] o
);
  logic        w_sb, w_swap, w_sx, w_sy;
  logic [7:0]  w_ea, w_eb, w_ex, w_ey, w_d;
  logic [23:0] w_ma, w_mb, w_mx, w_my, w_mant;
  logic [26:0] w_ye, w_mask, w_norm;
  logic [27:0] w_sum;
  logic [9:0]  w_exp;
  logic [4:0]  w_lz, w_sh;
  logic [24:0] w_rnd;

  always_comb begin
    w_sb   = b[31] ^ sub;
    w_ea   = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    w_eb   = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    w_ma   = {a[30:23] != 8'd0, a[22:0]};
    w_mb   = {b[30:23] != 8'd0, b[22:0]};
    w_swap = {w_eb, w_mb} > {w_ea, w_ma};
    w_sx   = w_swap ? w_sb : a[31];
    w_sy   = w_swap ? a[31] : w_sb;
    w_ex   = w_swap ? w_eb : w_ea;
    w_ey   = w_swap ? w_ea : w_eb;
    w_mx   = w_swap ? w_mb : w_ma;
    w_my   = w_swap ? w_ma : w_mb;
    w_d    = w_ex - w_ey;
    w_mask = '0;
    // Smaller operand aligned with guard/round bits and a sticky LSB.
    if (w_d > 8'd26) begin
      w_ye = {26'd0, |w_my};
    end else begin
      w_mask = (27'd1 << w_d) - 27'd1;
      w_ye   = ({w_my, 3'b000} >> w_d) | {26'd0, |({w_my, 3'b000} & w_mask)};
    end
    w_sum = (w_sx == w_sy) ? ({1'b0, w_mx, 3'b000} + {1'b0, w_ye})
                           : ({1'b0, w_mx, 3'b000} - {1'b0, w_ye});
    w_lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (w_sum[i]) w_lz = 5'(26 - i);
    end
    w_sh = '0;
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp  = {2'b00, w_ex} + 10'd1;
    end else begin
      w_sh   = ({5'd0, w_lz} > ({2'b00, w_ex} - 10'd1)) ? 5'(w_ex - 8'd1) : w_lz;
      w_norm = w_sum[26:0] << w_sh;
      w_exp  = {2'b00, w_ex} - {5'd0, w_sh};
    end
    w_rnd  = {1'b0, w_norm[26:3]} + {24'd0, w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3])};
    w_mant = w_rnd[23:0];
    if (w_rnd[24]) begin
      w_mant = w_rnd[24:1];
      w_exp  = w_exp + 10'd1;
    end
    if (!w_mant[23]) w_exp = '0;
    o = {w_sx, w_exp[7:0], w_mant[22:0]};
    if (w_exp >= 10'd255) o = {w_sx, 8'hFF, 23'd0};
    if (w_sum == 28'd0) o = {w_sx & w_sy, 31'd0};
    // Inf/NaN operands bypass the datapath.
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
          (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != w_sb))
        o = 32'h7FC00000;
      else if (a[30:23] == 8'hFF)
        o = a;
      else
        o = {w_sb, b[30:0]};
    end
  end
endmodule

module vec_add_accum #(
  parameter int LANES = 3,
  parameter int W     = 32,
  parameter int PIPE  = 2,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  vec_add_accum_if.slave bus
);
  localparam int VW = LANES * W;
  localparam logic [VW:0] NULL_WORD = {1'b1, {VW{1'b0}}};

  logic [VW-1:0]    r_acc;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [VW:0]      r_pipe_dat [PIPE];
  logic [CNT_W-1:0] r_pipe_cnt [PIPE];

  logic             w_acc_mode, w_a_vld, w_b_vld, w_acc_clr;
  logic [VW-1:0]    w_op_x, w_op_y, w_sum, w_acc_next;
  logic [CNT_W-1:0] w_cnt_next, w_s0_cnt;
  logic [VW:0]      w_s0_dat;

  assign w_acc_mode = bus.mode[1];
  assign w_a_vld    = ~bus.a[VW];
  assign w_b_vld    = ~bus.b[VW];
  assign w_acc_clr  = w_acc_mode & bus.flush;
  // One adder per lane serves both modes: a+-b element-wise, acc+-a when accumulating.
  assign w_op_x     = w_acc_mode ? r_acc : bus.a[VW-1:0];
  assign w_op_y     = w_acc_mode ? bus.a[VW-1:0] : bus.b[VW-1:0];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp32_add u_add (
      .a   (w_op_x[g*W +: W]),
      .b   (w_op_y[g*W +: W]),
      .sub (bus.mode[0]),
      .o   (w_sum[g*W +: W])
    );
  end

  always_comb begin
    w_acc_next = r_acc;
    w_cnt_next = r_acc_cnt;
    w_s0_dat   = NULL_WORD;
    w_s0_cnt   = '0;
    if (!w_acc_mode) begin
      if (w_a_vld && w_b_vld) w_s0_dat = {1'b0, w_sum};
    end else begin
      if (w_a_vld) begin
        w_acc_next = w_sum;
        if (r_acc_cnt != '1) w_cnt_next = r_acc_cnt + CNT_W'(1);
      end
      if (bus.flush && w_cnt_next != '0) begin
        w_s0_dat = {1'b0, w_acc_next};
        w_s0_cnt = w_cnt_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc     <= '0;
      r_acc_cnt <= '0;
      for (int i = 0; i < PIPE; i++) begin
        r_pipe_dat[i] <= NULL_WORD;
        r_pipe_cnt[i] <= '0;
      end
    end else begin
      r_acc         <= w_acc_clr ? '0 : w_acc_next;
      r_acc_cnt     <= w_acc_clr ? '0 : w_cnt_next;
      r_pipe_dat[0] <= w_s0_dat;
      r_pipe_cnt[0] <= w_s0_cnt;
      for (int i = 1; i < PIPE; i++) begin
        r_pipe_dat[i] <= r_pipe_dat[i-1];
        r_pipe_cnt[i] <= r_pipe_cnt[i-1];
      end
    end
  end

  assign bus.o        = r_pipe_dat[PIPE-1];
  assign bus.en       = ~r_pipe_dat[PIPE-1][VW];
  assign bus.o_count  = r_pipe_cnt[PIPE-1];
  assign bus.acc_busy = (r_acc_cnt != '0);
endmodule

// File: tb/tb_vec_add_accum.sv
// Bench for vec_add_accum: real-arithmetic reference model plus directed vectors.
module tb_vec_add_accum;
  localparam int LANES = 3;
  localparam int W     = 32;
  localparam int PIPE  = 2;
  localparam int CNT_W = 16;
  localparam int VW    = LANES * W;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [VW:0] NULLV = {1'b1, {VW{1'b0}}};
  localparam logic [31:0] F0P5 = 32'h3F000000, F1 = 32'h3F800000, F2 = 32'h40000000,
                          F3 = 32'h40400000, F4 = 32'h40800000, F5 = 32'h40A00000,
                          F6 = 32'h40C00000, FM2 = 32'hC0000000, FMH = 32'hBF000000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vec_add_accum_if #(.LANES(LANES), .W(W), .CNT_W(CNT_W)) bus ();
  vec_add_accum_if #(.LANES(LANES), .W(W), .CNT_W(2))     sbus ();

  vec_add_accum #(.LANES(LANES), .W(W), .PIPE(PIPE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  vec_add_accum #(.LANES(LANES), .W(W), .PIPE(PIPE), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(sbus));

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chkw(input string name, input logic [VW:0] act, input logic [VW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [VW:0] vec(input logic [31:0] x0, x1, x2);
    return {1'b0, x2, x1, x0};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    if (f[30:23] == 8'd0) return 0.0;
    return $bitstoreal({f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Reference model: expected output word per cycle, delayed PIPE edges.
  typedef struct {
    logic [VW:0] dat;
    int          cnt;
  } exp_t;
  exp_t q[$];
  real  acc_m [LANES];
  int   cnt_m = 0;
  exp_t s0;
  exp_t nul;
  real  ra, rb;

  always @(posedge clk) begin
    nul.dat = NULLV;
    nul.cnt = 0;
    s0 = nul;
    if (reset) begin
      for (int l = 0; l < LANES; l++) acc_m[l] = 0.0;
      cnt_m = 0;
      q.delete();
      for (int i = 0; i < PIPE; i++) q.push_back(nul);
    end else begin
      if (!bus.mode[1]) begin
        if (!bus.a[VW] && !bus.b[VW]) begin
          s0.dat[VW] = 1'b0;
          for (int l = 0; l < LANES; l++) begin
            ra = f2r(bus.a[l*W +: W]);
            rb = f2r(bus.b[l*W +: W]);
            s0.dat[l*W +: W] = r2f(bus.mode[0] ? ra - rb : ra + rb);
          end
        end
      end else begin
        if (!bus.a[VW]) begin
          for (int l = 0; l < LANES; l++) begin
            ra = f2r(bus.a[l*W +: W]);
            acc_m[l] = bus.mode[0] ? acc_m[l] - ra : acc_m[l] + ra;
          end
          if (cnt_m < CMAX) cnt_m++;
        end
        if (bus.flush) begin
          if (cnt_m != 0) begin
            s0.dat[VW] = 1'b0;
            for (int l = 0; l < LANES; l++) s0.dat[l*W +: W] = r2f(acc_m[l]);
            s0.cnt = cnt_m;
          end
          for (int l = 0; l < LANES; l++) acc_m[l] = 0.0;
          cnt_m = 0;
        end
      end
      q.push_back(s0);
      if (q.size() > PIPE) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (cmp_on && q.size() > 0) begin
      chkw("o", bus.o, q[0].dat);
      chkn("en", int'(bus.en), int'(!q[0].dat[VW]));
      chkn("o_count", int'(bus.o_count), q[0].cnt);
      chkn("acc_busy", int'(bus.acc_busy), int'(cnt_m != 0));
    end
  end

  task automatic cyc(input logic [VW:0] a, input logic [VW:0] b, input logic [1:0] m, input logic f);
    bus.a     = a;
    bus.b     = b;
    bus.mode  = m;
    bus.flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic scyc(input logic [VW:0] a, input logic f);
    sbus.a     = a;
    sbus.flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    sbus.a     = NULLV;
    sbus.b     = NULLV;
    sbus.mode  = 2'b10;
    sbus.flush = 1'b0;
    cyc(vec(F1, F2, F3), vec(F1, F1, F1), 2'b10, 1'b0);
    cyc(vec(F1, F2, F3), vec(F1, F1, F1), 2'b10, 1'b1);
    cmp_on = 1'b1;
    chkw("rst_o", bus.o, NULLV);
    chkn("rst_en", int'(bus.en), 0);
    chkn("rst_cnt", int'(bus.o_count), 0);
    chkn("rst_busy", int'(bus.acc_busy), 0);
    reset = 1'b0;
    repeat (3) cyc(NULLV, NULLV, 2'b00, 1'b0);

    for (int i = 0; i < 4; i++) begin
      cyc(vec(F1, F2, F3), vec(F1, F1, F1), 2'b00, 1'b0);
      if (i > 0) chkw("add_o", bus.o, vec(F2, F3, F4));
    end
    cyc(NULLV, vec(F1, F1, F1), 2'b00, 1'b0);
    chkw("add_last", bus.o, vec(F2, F3, F4));
    cyc(vec(F1, F2, F3), vec(F1, F1, F1), 2'b00, 1'b0);
    chkw("add_bubble", bus.o, NULLV);
    cyc(vec(F0P5, F0P5, F0P5), vec(F1, F1, F1), 2'b01, 1'b0);
    chkw("add_after_bubble", bus.o, vec(F2, F3, F4));
    cyc(NULLV, NULLV, 2'b00, 1'b0);
    chkw("sub_o", bus.o, vec(FMH, FMH, FMH));

    cyc(vec(F1, F1, F1), NULLV, 2'b10, 1'b0);
    chkn("acc_busy_1", int'(bus.acc_busy), 1);
    cyc(vec(F1, F1, F1), NULLV, 2'b10, 1'b0);
    cyc(NULLV, NULLV, 2'b10, 1'b0);
    cyc(vec(F1, F1, F1), NULLV, 2'b10, 1'b0);
    cyc(vec(F1, F1, F1), NULLV, 2'b10, 1'b0);
    cyc(vec(F1, F1, F1), NULLV, 2'b10, 1'b1);
    chkn("acc_busy_flushed", int'(bus.acc_busy), 0);
    cyc(NULLV, NULLV, 2'b10, 1'b0);
    chkw("acc5_o", bus.o, vec(F5, F5, F5));
    chkn("acc5_cnt", int'(bus.o_count), 5);

    cyc(vec(F1, F1, F1), NULLV, 2'b11, 1'b0);
    cyc(vec(F1, F1, F1), NULLV, 2'b11, 1'b0);
    cyc(NULLV, NULLV, 2'b11, 1'b1);
    cyc(NULLV, NULLV, 2'b11, 1'b1);
    chkw("accsub_o", bus.o, vec(FM2, FM2, FM2));
    chkn("accsub_cnt", int'(bus.o_count), 2);
    cyc(NULLV, NULLV, 2'b00, 1'b0);
    chkn("empty_flush_en", int'(bus.en), 0);

    cyc(vec(F1, F2, F3), NULLV, 2'b10, 1'b0);
    cyc(vec(F1, F2, F3), NULLV, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) cyc(vec(F1, F2, F3), vec(F1, F1, F1), 2'b00, 1'b1);
    chkn("interleave_busy", int'(bus.acc_busy), 1);
    chkw("interleave_ew", bus.o, vec(F2, F3, F4));
    cyc(NULLV, NULLV, 2'b10, 1'b1);
    cyc(NULLV, NULLV, 2'b00, 1'b0);
    chkw("interleave_flush", bus.o, vec(F2, F4, F6));
    chkn("interleave_cnt", int'(bus.o_count), 2);

    cyc(vec(F1, F1, F1), NULLV, 2'b10, 1'b0);
    cyc(vec(F1, F1, F1), NULLV, 2'b10, 1'b0);
    cyc(vec(F1, F2, F3), vec(F1, F1, F1), 2'b00, 1'b0);
    reset = 1'b1;
    cyc(vec(F1, F1, F1), NULLV, 2'b10, 1'b1);
    reset = 1'b0;
    chkn("midrst_busy", int'(bus.acc_busy), 0);
    chkw("midrst_o", bus.o, NULLV);
    cyc(NULLV, NULLV, 2'b10, 1'b1);
    cyc(NULLV, NULLV, 2'b00, 1'b0);
    chkn("midrst_flush_en", int'(bus.en), 0);

    for (int i = 0; i < 5; i++) scyc(vec(F1, F1, F1), i == 4);
    scyc(NULLV, 1'b0);
    chkw("sat_o", sbus.o, vec(F5, F5, F5));
    chkn("sat_cnt", int'(sbus.o_count), 3);
    chkn("sat_busy", int'(sbus.acc_busy), 0);

    repeat (3) cyc(NULLV, NULLV, 2'b00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
